// File: rtl/audio_mix_dac.sv
// Multi-channel audio mixer: serial gain/mute/saturating accumulate, then a first-order
// sigma-delta DAC. Define AUDIO_MIX_LPF_EN to insert a one-pole low-pass on the mixed sample.
module audio_mix_dac #(
    parameter int NUM_CH    = 3,
    parameter int IN_W      = 8,
    parameter int SUM_W     = 11,
    parameter int LPF_SHIFT = 2
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   sample_ce,
    input  logic [NUM_CH*IN_W-1:0] ch_in,
    input  logic [2*NUM_CH-1:0]    ch_gain,
    input  logic [NUM_CH-1:0]      ch_mute,
    output logic [SUM_W-1:0]       mix_out,
    output logic                   mix_valid,
    output logic                   overrun,
    output logic                   dac_o
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SLOTS = 1 << IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t                   r_state, w_next;
    logic [IDX_W-1:0]         r_ch_idx;
    logic [SUM_W-1:0]         r_acc, r_mix_out;
    logic                     r_overrun, r_dac;
    logic [SUM_W:0]           r_sd_acc;
    logic [NUM_CH*IN_W-1:0]   r_snap_in;
    logic [2*NUM_CH-1:0]      r_snap_gain;
    logic [NUM_CH-1:0]        r_snap_mute;

    logic [IN_W-1:0]          w_ch   [SLOTS];
    logic [1:0]               w_gn   [SLOTS];
    logic                     w_mt   [SLOTS];
    logic [SUM_W-1:0]         w_ext, w_term, w_acc_next, w_mix_next;
    logic [SUM_W:0]           w_sum;
    logic                     w_idle, w_last;

    // Unused slots (NUM_CH not a power of two) read as muted zeros
    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        if (k < NUM_CH) begin : g_used
            assign w_ch[k] = r_snap_in[k*IN_W +: IN_W];
            assign w_gn[k] = r_snap_gain[2*k +: 2];
            assign w_mt[k] = r_snap_mute[k];
        end else begin : g_pad
            assign w_ch[k] = '0;
            assign w_gn[k] = '0;
            assign w_mt[k] = 1'b1;
        end
    end

    assign w_ext      = SUM_W'(w_ch[r_ch_idx]);
    assign w_term     = w_mt[r_ch_idx] ? '0 : (w_ext << w_gn[r_ch_idx]);
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_term};
    assign w_acc_next = w_sum[SUM_W] ? '1 : w_sum[SUM_W-1:0];

`ifdef AUDIO_MIX_LPF_EN
    logic signed [SUM_W:0] r_lpf_y, w_lpf_diff, w_lpf_next;
    // y stays between its old value and the new sum, so it never leaves 0..2^SUM_W-1
    assign w_lpf_diff = $signed({1'b0, w_acc_next}) - r_lpf_y;
    assign w_lpf_next = r_lpf_y + (w_lpf_diff >>> LPF_SHIFT);
    assign w_mix_next = w_lpf_next[SUM_W-1:0];

    always_ff @(posedge clk_sys) begin
        if (reset)       r_lpf_y <= '0;
        else if (w_last) r_lpf_y <= w_lpf_next;
    end
`else
    assign w_mix_next = w_acc_next;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (sample_ce) w_next = S_ACCUM;
            S_ACCUM: if (r_ch_idx == IDX_W'(NUM_CH-1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_idle    = (r_state == S_IDLE);
        w_last    = (r_state == S_ACCUM) && (r_ch_idx == IDX_W'(NUM_CH-1));
        mix_valid = (r_state == S_DONE);
    end

    // mix_out is loaded on entry to DONE so it is valid while mix_valid is high
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_acc       <= '0;
            r_ch_idx    <= '0;
            r_mix_out   <= '0;
            r_overrun   <= 1'b0;
            r_snap_in   <= '0;
            r_snap_gain <= '0;
            r_snap_mute <= '0;
        end else begin
            if (sample_ce && w_idle) begin
                r_snap_in   <= ch_in;
                r_snap_gain <= ch_gain;
                r_snap_mute <= ch_mute;
                r_acc       <= '0;
                r_ch_idx    <= '0;
            end
            if (r_state == S_ACCUM) begin
                r_acc    <= w_acc_next;
                r_ch_idx <= r_ch_idx + IDX_W'(1);
            end
            if (w_last)               r_mix_out <= w_mix_next;
            if (sample_ce && !w_idle) r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sd_acc <= '0;
            r_dac    <= 1'b0;
        end else begin
            r_sd_acc <= {1'b0, r_sd_acc[SUM_W-1:0]} + {1'b0, r_mix_out};
            r_dac    <= r_sd_acc[SUM_W];
        end
    end

    assign mix_out = r_mix_out;
    assign overrun = r_overrun;
    assign dac_o   = r_dac;
endmodule

// File: tb/tb_audio_mix_dac.sv
// Self-checking bench for audio_mix_dac: vector table, random mixes against an arithmetic
// model, and hand sequences for overrun, reset abort and the sigma-delta density.
module tb_audio_mix_dac;
    localparam int NUM_CH = 3, IN_W = 8, SUM_W = 11, LPF_SHIFT = 2;
    localparam int MAXV = (1 << SUM_W) - 1;

    logic                   clk_sys = 1'b0, reset = 1'b1, sample_ce = 1'b0;
    logic [NUM_CH*IN_W-1:0] ch_in = '0;
    logic [2*NUM_CH-1:0]    ch_gain = '0;
    logic [NUM_CH-1:0]      ch_mute = '0;
    logic [SUM_W-1:0]       mix_out;
    logic                   mix_valid, overrun, dac_o;

    int errors = 0, checks = 0, ref_y = 0;

    audio_mix_dac #(.NUM_CH(NUM_CH), .IN_W(IN_W), .SUM_W(SUM_W), .LPF_SHIFT(LPF_SHIFT)) dut (
        .clk_sys(clk_sys), .reset(reset), .sample_ce(sample_ce), .ch_in(ch_in),
        .ch_gain(ch_gain), .ch_mute(ch_mute), .mix_out(mix_out), .mix_valid(mix_valid),
        .overrun(overrun), .dac_o(dac_o)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [23:0] ci;
        logic [5:0]  g;
        logic [2:0]  m;
        int          exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Sum of unmuted samples scaled by 2^gain, clamped to the mix range
    function automatic int mix_model(input logic [23:0] ci, input logic [5:0] g, input logic [2:0] m);
        int total = 0;
        for (int k = 0; k < NUM_CH; k++)
            if (!m[k]) total += int'(ci[k*IN_W +: IN_W]) * (1 << g[2*k +: 2]);
        return (total > MAXV) ? MAXV : total;
    endfunction

    function automatic int lpf_model(input int y, input int s);
        int d = s - y, den = 1 << LPF_SHIFT;
        int q = (d >= 0) ? d / den : -((-d + den - 1) / den);
        return y + q;
    endfunction

    task automatic model_out(input int s, output int e);
`ifdef AUDIO_MIX_LPF_EN
        ref_y = lpf_model(ref_y, s);
        e = ref_y;
`else
        e = s;
`endif
    endtask

    task automatic count_pulses(input int n, output int c, output int last_val);
        c = 0;
        last_val = -1;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (mix_valid) begin
                c++;
                last_val = int'(mix_out);
            end
        end
    endtask

    task automatic count_ones(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (dac_o) c++;
        end
    endtask

    // One full mix; inputs are scrambled after acceptance to prove the snapshot holds
    task automatic run_mix(input logic [23:0] ci, input logic [5:0] g, input logic [2:0] m,
                           input string name, output int e);
        int lat;
        ch_in = ci; ch_gain = g; ch_mute = m; sample_ce = 1'b1;
        step(1);
        sample_ce = 1'b0;
        ch_in = 24'($urandom); ch_gain = 6'($urandom); ch_mute = 3'($urandom);
        lat = 1;
        while (!mix_valid && lat < 20) begin
            step(1);
            lat++;
        end
        model_out(mix_model(ci, g, m), e);
        check({name, " latency"}, lat, NUM_CH + 1);
        check({name, " mix_out"}, mix_out, e);
        step(1);
        check({name, " valid width"}, mix_valid, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; sample_ce = 1'b0;
        step(2);
        reset = 1'b0;
        ref_y = 0;
    endtask

    vec_t tbl[10];
    int   e, c, v;

    initial begin
        tbl[0] = '{24'h402010, 6'b01_10_00, 3'b000, 'h110};
        tbl[1] = '{24'hFFFFFF, 6'b11_11_11, 3'b000, 'h7FF};
        tbl[2] = '{24'h402010, 6'b00_00_00, 3'b010, 'h050};
        tbl[3] = '{24'h000000, 6'b11_11_11, 3'b000, 'h000};
        tbl[4] = '{24'h0000FF, 6'b00_00_11, 3'b000, 'h7F8};
        tbl[5] = '{24'h0001FF, 6'b00_00_11, 3'b000, 'h7F9};
        tbl[6] = '{24'h0007FF, 6'b00_00_11, 3'b000, 'h7FF};
        tbl[7] = '{24'h0008FF, 6'b00_00_11, 3'b000, 'h7FF};
        tbl[8] = '{24'hFFFFFF, 6'b11_11_11, 3'b111, 'h000};
        tbl[9] = '{24'h808080, 6'b00_01_10, 3'b000, 'h380};

        step(3);
        check("rst mix_out", mix_out, 0);
        check("rst mix_valid", mix_valid, 0);
        check("rst overrun", overrun, 0);
        check("rst dac_o", dac_o, 0);
        reset = 1'b0;

        // Back-to-back: each mix starts on the first cycle it may be accepted
        foreach (tbl[i]) begin
            run_mix(tbl[i].ci, tbl[i].g, tbl[i].m, $sformatf("vec%0d", i), e);
`ifndef AUDIO_MIX_LPF_EN
            check($sformatf("vec%0d table", i), mix_out, tbl[i].exp);
`endif
        end
        check("b2b no overrun", overrun, 0);

        for (int i = 0; i < 30; i++)
            run_mix(24'($urandom), 6'($urandom), 3'($urandom_range(0, 7) == 0 ? $urandom : 0),
                    $sformatf("rnd%0d", i), e);

        // Second strobe two cycles in is dropped and flags overrun
        do_reset();
        check("ovr clear", overrun, 0);
        ch_in = 24'h402010; ch_gain = '0; ch_mute = 3'b010; sample_ce = 1'b1;
        step(1);
        sample_ce = 1'b0;
        step(1);
        sample_ce = 1'b1;
        step(1);
        sample_ce = 1'b0;
        count_pulses(10, c, v);
        model_out(mix_model(24'h402010, 6'd0, 3'b010), e);
        check("ovr pulses", c, 1);
        check("ovr mix_out", v, e);
        check("ovr sticky", overrun, 1);
        run_mix(24'h000011, 6'd0, 3'd0, "ovr after", e);
        check("ovr still set", overrun, 1);

        // Strobe during DONE is also ignored
        do_reset();
        ch_in = 24'h000020; ch_gain = '0; ch_mute = '0; sample_ce = 1'b1;
        step(1);
        sample_ce = 1'b0;
        c = 1;
        while (!mix_valid && c < 20) begin step(1); c++; end
        check("done lat", c, NUM_CH + 1);
        model_out(32, e);
        sample_ce = 1'b1;
        step(1);
        sample_ce = 1'b0;
        check("done ovr", overrun, 1);
        count_pulses(8, c, v);
        check("done no mix", c, 0);

        // Reset two cycles into a mix abandons it
        run_mix(24'h303030, 6'b01_01_01, 3'd0, "pre abort", e);
        ch_in = 24'h123456; sample_ce = 1'b1;
        step(1);
        sample_ce = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        check("abort valid", mix_valid, 0);
        check("abort mix_out", mix_out, 0);
        check("abort dac_o", dac_o, 0);
        check("abort overrun", overrun, 0);
        reset = 1'b0; ref_y = 0;
        count_pulses(8, c, v);
        check("abort no pulse", c, 0);
        run_mix(24'h010203, 6'b00_01_10, 3'd0, "after abort", e);

        // Reset wins over a simultaneous strobe
        reset = 1'b1; sample_ce = 1'b1;
        step(1);
        reset = 1'b0; sample_ce = 1'b0; ref_y = 0;
        count_pulses(8, c, v);
        check("rst prio", c, 0);

        // Sigma-delta density: ones per 2^SUM_W cycles equals the held mix value
        run_mix(24'h000080, 6'b00_00_10, 3'd0, "sd 0x200", e);
        step(3);
        count_ones(1 << SUM_W, c);
        check("sd ones 0x200", c, e);
        run_mix(24'($urandom), 6'($urandom), 3'd0, "sd rnd", e);
        step(3);
        count_ones(1 << SUM_W, c);
        check("sd ones rnd", c, e);
        do_reset();
        count_ones(200, c);
        check("sd zero", c, 0);

`ifdef AUDIO_MIX_LPF_EN
        do_reset();
        run_mix(24'h000080, 6'b00_00_11, 3'd0, "lpf1", e);
        check("lpf step1", mix_out, 'h100);
        run_mix(24'h000080, 6'b00_00_11, 3'd0, "lpf2", e);
        check("lpf step2", mix_out, 'h1C0);
        run_mix(24'h000080, 6'b00_00_11, 3'd0, "lpf3", e);
        check("lpf step3", mix_out, 'h250);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
